pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles to drain the MEM and WB stages after HALT reaches EXE.
REQ-002 Parameter BUSY_TIMEOUT, default 255: maximum consecutive mem_busy cycles before an error is flagged.
REQ-003 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; starts execution from IDLE or HALTED.
REQ-006 id_ir  in  32  instruction currently in ID.
REQ-007 exe_ir  in  32  instruction currently in EXE.
REQ-008 IsBranchTaken  in  1  EXE-stage branch/jump resolution, valid while running.
REQ-009 mem_busy  in  1  data memory has not completed its access.
REQ-010 if_stall, id_stall, exe_stall  out  1 each  hold the stage register (drives IsStall).
REQ-011 id_flush, exe_flush  out  1 each  replace the stage's next contents with NOP.
REQ-012 running  out  1  high in RUN, LU_STALL, FLUSH, MEM_WAIT.
REQ-013 halted  out  1  high in HALTED.
REQ-014 busy_err  out  1  sticky mem_busy timeout flag.
REQ-015 stall_count  out  16  saturating count of cycles with if_stall high.

Function
REQ-016 States SHALL be IDLE, RUN, LU_STALL, FLUSH, MEM_WAIT, DRAIN, HALTED.
REQ-017 In IDLE and HALTED, all stall outputs SHALL be 1, all flush outputs 0, and start SHALL move to RUN on the next edge.
REQ-018 Opcode SHALL be IR[31:26], rs IR[25:21], rt IR[20:16], decoded against the ISA encodings.
REQ-019 Load-use SHALL be: exe opcode in {LW, LH, LD}, exe rt != 0, and exe rt equals id rs or id rt.
REQ-020 Evaluation priority in RUN: mem_busy > IsBranchTaken > exe opcode HALT > load-use.
REQ-021 For mem_busy=1 in RUN, the block SHALL go to MEM_WAIT, with if/id/exe_stall=1 combinationally in the same cycle.
REQ-022 MEM_WAIT SHALL hold all stalls while mem_busy=1 and return to RUN on the first edge with mem_busy=0.
REQ-023 A busy counter SHALL count consecutive mem_busy cycles; when it reaches BUSY_TIMEOUT, busy_err SHALL set, the state SHALL go to HALTED, and the counter SHALL clear.
REQ-024 For IsBranchTaken=1 in RUN, id_flush=1 and exe_flush=1 SHALL be asserted combinationally that cycle, followed by FLUSH for exactly one cycle (id_flush=1 only), then RUN.
REQ-025 Branch-taken together with load-use SHALL flush only and insert no stall.
REQ-026 For load-use, if_stall=id_stall=1 and exe_flush=1 SHALL be asserted in the same cycle (one bubble), followed by LU_STALL for exactly one cycle with no outputs asserted, then RUN.
REQ-027 For HALT in EXE, if_stall=id_stall=1 and exe_flush=1 SHALL be asserted, the state SHALL go to DRAIN, and a down-counter SHALL load DRAIN_CYCLES-1.
REQ-028 DRAIN SHALL keep if/id_stall=1 and exe_flush=1, and SHALL go to HALTED when the counter reads 0; mem_busy in DRAIN SHALL freeze the counter.
REQ-029 Start SHALL be ignored outside IDLE and HALTED.
REQ-030 stall_count SHALL increment on each edge with if_stall=1 while running=1, and saturate at 16'hFFFF.
REQ-031 All flush and stall outputs SHALL be glitch-free functions of the registered state plus current inputs; there are no other combinational paths.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, all stalls 1, all flushes 0, running 0, halted 0, busy_err 0, stall_count 0, and both internal counters 0.
REQ-033 Reset mid-operation (any state) SHALL abandon the state; after release, only start leaves IDLE.
REQ-034 busy_err SHALL clear only on reset.

Verification
REQ-035 Reset, start pulse, NOP stream -> running=1 next cycle; all stalls/flushes 0; stall_count stays 0.
REQ-036 exe_ir=LW rt=5, id_ir=ADD rs=5 -> exactly one cycle of if/id_stall=1 with exe_flush=1; stall_count=1; RUN after 2 cycles.
REQ-037 LW rt=5 in EXE with IsBranchTaken=1 same cycle -> id/exe_flush=1, then id_flush=1 one cycle, no stall, stall_count=0.
REQ-038 mem_busy high 3 cycles -> all stalls 1 for 3 cycles, stall_count=3, RUN on 4th; with BUSY_TIMEOUT=4 and mem_busy held -> busy_err=1, halted=1 after 4 cycles.
REQ-039 HALT in EXE, DRAIN_CYCLES=2 -> 2 DRAIN cycles, then halted=1; start -> running=1.
REQ-040 rst_n low during MEM_WAIT -> outputs reach reset values without a clock edge; busy_err=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage core (hazards, mem wait, halt drain).
// In: start, id_ir, exe_ir, IsBranchTaken, mem_busy. Out: if/id/exe_stall, id/exe_flush,
// running, halted, busy_err (sticky), stall_count (saturating).
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] id_ir,
  input  logic [31:0] exe_ir,
  input  logic        IsBranchTaken,
  input  logic        mem_busy,
  output logic        if_stall,
  output logic        id_stall,
  output logic        exe_stall,
  output logic        id_flush,
  output logic        exe_flush,
  output logic        running,
  output logic        halted,
  output logic        busy_err,
  output logic [15:0] stall_count
);

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LD   = 6'h37;
  localparam logic [5:0] OP_HALT = 6'h3f;

  localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] BUSY_LIM   = 16'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LU_STALL,
    S_FLUSH,
    S_MEM_WAIT,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [15:0] drain_cnt;
  logic [15:0] busy_cnt;

  logic [5:0] exe_op;
  logic [4:0] exe_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       is_load;
  logic       is_halt;
  logic       load_use;
  logic       busy_cnt_en;
  logic       timeout;
  logic       go_drain;
  logic       unused_bits;

  assign exe_op = exe_ir[31:26];
  assign exe_rt = exe_ir[20:16];
  assign id_rs  = id_ir[25:21];
  assign id_rt  = id_ir[20:16];

  assign unused_bits = ^{id_ir[31:26], id_ir[15:0], exe_ir[25:21], exe_ir[15:0]};

  assign is_load  = exe_op inside {OP_LW, OP_LH, OP_LD};
  assign is_halt  = exe_op == OP_HALT;
  assign load_use = is_load && (exe_rt != 5'd0)
                 && ((exe_rt == id_rs) || (exe_rt == id_rt));

  // Only states where a memory access can be outstanding
  // accumulate toward the timeout; any other cycle restarts it.
  assign busy_cnt_en = mem_busy
                    && (state inside {S_RUN, S_MEM_WAIT, S_DRAIN});
  assign timeout     = busy_cnt_en && (busy_cnt + 16'd1 == BUSY_LIM);

  assign go_drain = (state == S_RUN) && !mem_busy
                 && !IsBranchTaken && is_halt;

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE, S_HALTED: if (start) state_d = S_RUN;
      S_RUN: begin
        if (mem_busy)           state_d = S_MEM_WAIT;
        else if (IsBranchTaken) state_d = S_FLUSH;
        else if (is_halt)       state_d = S_DRAIN;
        else if (load_use)      state_d = S_LU_STALL;
      end
      S_LU_STALL, S_FLUSH: state_d = S_RUN;
      S_MEM_WAIT: if (!mem_busy) state_d = S_RUN;
      S_DRAIN: begin
        if (!mem_busy && drain_cnt == 16'd0) state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_HALTED;
  end

  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    exe_stall = 1'b0;
    id_flush  = 1'b0;
    exe_flush = 1'b0;
    unique case (state)
      S_IDLE, S_HALTED: begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        exe_stall = 1'b1;
      end
      S_RUN: begin
        if (mem_busy) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          exe_stall = 1'b1;
        end else if (IsBranchTaken) begin
          // branch wins over load-use: the load's consumer is flushed anyway
          id_flush  = 1'b1;
          exe_flush = 1'b1;
        end else if (is_halt || load_use) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          exe_flush = 1'b1;
        end
      end
      S_FLUSH: id_flush = 1'b1;
      S_MEM_WAIT: begin
        if_stall  = mem_busy;
        id_stall  = mem_busy;
        exe_stall = mem_busy;
      end
      S_DRAIN: begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        exe_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      running     <= 1'b0;
      halted      <= 1'b0;
      busy_err    <= 1'b0;
      drain_cnt   <= 16'd0;
      busy_cnt    <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      state   <= state_d;
      running <= state_d inside {S_RUN, S_LU_STALL, S_FLUSH, S_MEM_WAIT};
      halted  <= state_d == S_HALTED;
      if (timeout) busy_err <= 1'b1;
      busy_cnt <= (busy_cnt_en && !timeout) ? busy_cnt + 16'd1 : 16'd0;
      if (go_drain)
        drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN && !mem_busy && drain_cnt != 16'd0)
        drain_cnt <= drain_cnt - 16'd1;
      if (running && if_stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized bench for pipe_ctrl
// against a flag-based behavioural model.
module tb_pipe_ctrl;

  localparam int DC = 2;
  localparam int BT = 4;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LD   = 6'h37;
  localparam logic [5:0] OP_HALT = 6'h3f;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] id_ir = '0;
  logic [31:0] exe_ir = '0;
  logic        br = 1'b0;
  logic        mem_busy = 1'b0;
  logic        if_stall, id_stall, exe_stall;
  logic        id_flush, exe_flush;
  logic        running, halted, busy_err;
  logic [15:0] stall_count;

  pipe_ctrl #(.DRAIN_CYCLES(DC), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .id_ir(id_ir), .exe_ir(exe_ir),
    .IsBranchTaken(br), .mem_busy(mem_busy),
    .if_stall(if_stall), .id_stall(id_stall), .exe_stall(exe_stall),
    .id_flush(id_flush), .exe_flush(exe_flush),
    .running(running), .halted(halted), .busy_err(busy_err),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pipeline activity described by flags, not by a state code.
  bit m_active = 0;
  bit m_halted = 0;
  bit m_bubble = 0;
  bit m_flush2 = 0;
  bit m_wait = 0;
  bit m_err = 0;
  int m_drain = -1;
  int m_busy = 0;
  int m_cnt = 0;

  function automatic bit lu_hit();
    logic [5:0] op;
    logic [4:0] rt;
    op = exe_ir[31:26];
    rt = exe_ir[20:16];
    return (op == OP_LW || op == OP_LH || op == OP_LD) && rt != 0
        && (rt == id_ir[25:21] || rt == id_ir[20:16]);
  endfunction

  // {if_stall, id_stall, exe_stall, id_flush, exe_flush}
  function automatic logic [4:0] exp_ctl();
    if (!rst_n) return 5'b11100;
    if (m_drain >= 0) return 5'b11001;
    if (!m_active) return 5'b11100;
    if (m_wait) return mem_busy ? 5'b11100 : 5'b00000;
    if (m_bubble) return 5'b00000;
    if (m_flush2) return 5'b00010;
    if (mem_busy) return 5'b11100;
    if (br) return 5'b00011;
    if (exe_ir[31:26] == OP_HALT) return 5'b11001;
    if (lu_hit()) return 5'b11001;
    return 5'b00000;
  endfunction

  task automatic model_reset();
    m_active = 0; m_halted = 0; m_bubble = 0; m_flush2 = 0;
    m_wait = 0; m_err = 0; m_drain = -1; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [4:0] o;
    bit plain_run;
    o = exp_ctl();
    plain_run = m_active && !m_wait && !m_bubble && !m_flush2;
    if (m_active && o[4] && m_cnt < 65535) m_cnt++;
    if ((plain_run || m_wait || m_drain >= 0) && mem_busy) m_busy++;
    else m_busy = 0;
    if (m_busy == BT) begin
      m_err = 1; m_busy = 0; m_active = 0; m_halted = 1;
      m_wait = 0; m_drain = -1;
    end else if (m_drain >= 0) begin
      if (!mem_busy) begin
        if (m_drain == 0) begin m_drain = -1; m_halted = 1; end
        else m_drain--;
      end
    end else if (!m_active) begin
      if (start) begin m_active = 1; m_halted = 0; end
    end else if (m_wait) m_wait = mem_busy;
    else if (m_bubble) m_bubble = 0;
    else if (m_flush2) m_flush2 = 0;
    else if (mem_busy) m_wait = 1;
    else if (br) m_flush2 = 1;
    else if (exe_ir[31:26] == OP_HALT) begin m_active = 0; m_drain = DC - 1; end
    else if (lu_hit()) m_bubble = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("ctl", 32'({if_stall, id_stall, exe_stall, id_flush, exe_flush}),
        32'(exp_ctl()));
    chk("running", 32'(running), 32'(m_active));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("busy_err", 32'(busy_err), 32'(m_err));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
  end

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(bit s, logic [31:0] id, logic [31:0] ex, bit b, bit mb);
    start = s; id_ir = id; exe_ir = ex; br = b; mem_busy = mb;
  endtask

  int burst = 0;

  initial begin
    // reset state
    tick();
    chk("rst_stalls", 32'({if_stall, id_stall, exe_stall}), 32'h7);
    chk("rst_flush", 32'({id_flush, exe_flush}), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_count", 32'(stall_count), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(running), 32'h0);

    // start + NOP stream
    drv(1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    #1;
    chk("start_running", 32'(running), 32'h1);
    chk("nop_ctl", 32'({if_stall, id_stall, exe_stall, id_flush, exe_flush}), 32'h0);
    repeat (3) tick();
    chk("nop_count", 32'(stall_count), 32'h0);

    // load-use bubble
    drv(0, mk(6'h00, 5, 6), mk(OP_LW, 1, 5), 0, 0);
    #1;
    chk("lu_ctl", 32'({if_stall, id_stall, exe_stall, id_flush, exe_flush}), 32'b11001);
    tick();
    drv(0, 0, 0, 0, 0);
    #1;
    chk("lu_stall_ctl", 32'({if_stall, exe_flush}), 32'h0);
    tick();
    chk("lu_count", 32'(stall_count), 32'h1);

    // branch with load-use: flush only
    drv(0, mk(6'h00, 5, 6), mk(OP_LW, 1, 5), 1, 0);
    #1;
    chk("br_ctl", 32'({if_stall, id_stall, exe_stall, id_flush, exe_flush}), 32'b00011);
    tick();
    drv(0, 0, 0, 0, 0);
    #1;
    chk("flush2_ctl", 32'({if_stall, id_stall, exe_stall, id_flush, exe_flush}), 32'b00010);
    tick();
    chk("br_count", 32'(stall_count), 32'h1);

    // 3-cycle memory wait
    drv(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stall", 32'({if_stall, id_stall, exe_stall}), 32'h7);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    #1;
    chk("mw_release", 32'(if_stall), 32'h0);
    tick();
    chk("mw_count", 32'(stall_count), 32'h4);
    chk("mw_running", 32'(running), 32'h1);

    // busy timeout
    drv(0, 0, 0, 0, 1);
    repeat (3) tick();
    chk("to_not_yet", 32'(halted), 32'h0);
    tick();
    chk("to_halted", 32'(halted), 32'h1);
    chk("to_err", 32'(busy_err), 32'h1);
    drv(1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("restart", 32'(running), 32'h1);

    // halt drain
    drv(0, 0, mk(OP_HALT, 0, 0), 0, 0);
    #1;
    chk("halt_ctl", 32'({if_stall, id_stall, exe_stall, id_flush, exe_flush}), 32'b11001);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("drain1", 32'({running, halted}), 32'h0);
    tick();
    chk("drain2", 32'({running, halted}), 32'h0);
    tick();
    chk("drained", 32'(halted), 32'h1);
    drv(1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("rerun", 32'(running), 32'h1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int p;
      logic [5:0] op;
      tick();
      rst_n = ($urandom_range(0, 499) != 0);
      start = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 7) == 0);
      if (burst > 0) begin
        mem_busy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        mem_busy = 1'b1;
        burst = $urandom_range(0, 4);
      end else mem_busy = 1'b0;
      p = $urandom_range(0, 39);
      if (p == 0) op = OP_HALT;
      else if (p < 5) op = OP_LW;
      else if (p < 9) op = OP_LH;
      else if (p < 13) op = OP_LD;
      else if (p < 16) op = 6'($urandom);
      else op = 6'h00;
      exe_ir = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      id_ir = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               16'($urandom)};
    end

    // reset during MEM_WAIT with busy_err set
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drv(1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 1);
    repeat (4) tick();
    chk("pre_err", 32'(busy_err), 32'h1);
    drv(1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 1);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_stalls", 32'({if_stall, id_stall, exe_stall}), 32'h7);
    chk("ar_flush", 32'({id_flush, exe_flush}), 32'h0);
    chk("ar_flags", 32'({running, halted, busy_err}), 32'h0);
    chk("ar_count", 32'(stall_count), 32'h0);
    drv(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("ar_idle", 32'(running), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
